// File: rtl/fetch_inflight_tracker.sv
// In-order tracker for outstanding instruction-fetch requests. Holds per-request
// {fault, subunit, attr}, steers each completion from the owning sub-unit, drops
// completions belonging to flushed requests, drains for instruction fences and
// flags completions that do not belong to the oldest outstanding request.
module fetch_inflight_tracker #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned NUM_SUB_UNITS = 3,
  parameter int unsigned ATTR_W        = 34,
  localparam int unsigned SUB_W        = (NUM_SUB_UNITS > 1) ? $clog2(NUM_SUB_UNITS) : 1,
  localparam int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_fault,
  input  logic [SUB_W-1:0]            req_subunit,
  input  logic [ATTR_W-1:0]           req_attr,
  output logic [NUM_SUB_UNITS-1:0]    sub_new_request,
  input  logic [NUM_SUB_UNITS-1:0]    unit_data_valid,
  input  logic [32*NUM_SUB_UNITS-1:0] unit_data,
  output logic                        rsp_valid,
  output logic [31:0]                 rsp_data,
  output logic                        rsp_fault,
  output logic [ATTR_W-1:0]           rsp_attr,
  output logic [CNT_W-1:0]            inflight_count,
  input  logic                        ifence,
  output logic                        ifence_start,
  output logic                        protocol_error
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic FenceIdle    = 1'b0;
  localparam logic FencePending = 1'b1;

  logic              fault_mem [DEPTH];
  logic [SUB_W-1:0]  sub_mem   [DEPTH];
  logic [ATTR_W-1:0] attr_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic             fence_q, fence_d;
  logic             perr_q, perr_d;

  logic             full, empty;
  logic             accept, head_done;
  logic             head_fault;
  logic [SUB_W-1:0] head_sub;
  logic             head_unit_valid;
  logic [31:0]      head_unit_data;
  logic             stray_valid;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  assign head_fault = fault_mem[rd_ptr_q];
  assign head_sub   = sub_mem[rd_ptr_q];

  // No accept while rst is high so sub_new_request holds its reset value.
  assign req_ready = ~full & (fence_q == FenceIdle);
  assign accept    = req_valid & req_ready & ~rst;

  // Select the head's sub-unit return and detect any valid that is not the head's.
  always_comb begin
    head_unit_valid = 1'b0;
    head_unit_data  = '0;
    stray_valid     = 1'b0;
    for (int i = 0; i < NUM_SUB_UNITS; i++) begin
      if (head_sub == SUB_W'(i)) begin
        head_unit_valid = unit_data_valid[i];
        head_unit_data  = unit_data[32*i +: 32];
      end
      if (unit_data_valid[i] && (empty || (head_sub != SUB_W'(i)))) begin
        stray_valid = 1'b1;
      end
    end
  end

  assign head_done = ~empty & (head_fault | head_unit_valid);

  // A completion in the flush cycle is dropped by the flush itself rather than
  // through discard_q, which only covers what is still outstanding afterwards.
  assign rsp_valid = head_done & ~flush & (discard_q == '0);
  assign rsp_data  = head_unit_data;
  assign rsp_fault = head_fault;
  assign rsp_attr  = attr_mem[rd_ptr_q];

  // One-hot launch strobe towards the target sub-unit; faults issue no access.
  always_comb begin
    sub_new_request = '0;
    for (int i = 0; i < NUM_SUB_UNITS; i++) begin
      if (accept && !req_fault && (req_subunit == SUB_W'(i))) begin
        sub_new_request[i] = 1'b1;
      end
    end
  end

  assign inflight_count = count_q;
  assign ifence_start   = (fence_q == FencePending) && (count_q == '0);
  assign protocol_error = perr_q;

  // Next-state for pointers, occupancy, discard counter, fence FSM and error flag.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q + CNT_W'(accept) - CNT_W'(head_done);
    discard_d = discard_q;
    fence_d   = fence_q;
    perr_d    = perr_q | stray_valid;

    if (accept) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (head_done) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end

    if (flush) begin
      discard_d = count_d;
    end else if (head_done && (discard_q != '0)) begin
      discard_d = discard_q - 1'b1;
    end

    unique case (fence_q)
      FenceIdle:    if (ifence) fence_d = FencePending;
      FencePending: if (count_q == '0) fence_d = FenceIdle;
      default:      fence_d = FenceIdle;
    endcase
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      discard_q <= '0;
      fence_q   <= FenceIdle;
      perr_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      discard_q <= discard_d;
      fence_q   <= fence_d;
      perr_q    <= perr_d;
    end
  end

  // Entry storage; contents are only observed once the occupancy covers them.
  always_ff @(posedge clk) begin
    if (accept) begin
      fault_mem[wr_ptr_q] <= req_fault;
      sub_mem[wr_ptr_q]   <= req_subunit;
      attr_mem[wr_ptr_q]  <= req_attr;
    end
  end

endmodule

// File: tb/tb_fetch_inflight_tracker.sv
// Directed bench: stimulus pushes expected responses into a queue, a negedge
// monitor pops and compares whenever rsp_valid is seen.
module tb_fetch_inflight_tracker;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned NSU    = 3;
  localparam int unsigned ATTR_W = 34;

  typedef struct packed {
    logic [31:0]       data;
    logic              chk_data;
    logic              fault;
    logic [ATTR_W-1:0] attr;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              req_valid;
  logic              req_ready;
  logic              req_fault;
  logic [1:0]        req_subunit;
  logic [ATTR_W-1:0] req_attr;
  logic [NSU-1:0]    sub_new_request;
  logic [NSU-1:0]    unit_data_valid;
  logic [32*NSU-1:0] unit_data;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic              rsp_fault;
  logic [ATTR_W-1:0] rsp_attr;
  logic [2:0]        inflight_count;
  logic              ifence;
  logic              ifence_start;
  logic              protocol_error;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  exp_t e;

  fetch_inflight_tracker #(
    .DEPTH        (DEPTH),
    .NUM_SUB_UNITS(NSU),
    .ATTR_W       (ATTR_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_fault      (req_fault),
    .req_subunit    (req_subunit),
    .req_attr       (req_attr),
    .sub_new_request(sub_new_request),
    .unit_data_valid(unit_data_valid),
    .unit_data      (unit_data),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_fault      (rsp_fault),
    .rsp_attr       (rsp_attr),
    .inflight_count (inflight_count),
    .ifence         (ifence),
    .ifence_start   (ifence_start),
    .protocol_error (protocol_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic expect_rsp(input logic [31:0] d, input logic cd, input logic f,
                            input logic [ATTR_W-1:0] a);
    exp_t x;
    x.data = d; x.chk_data = cd; x.fault = f; x.attr = a;
    exp_q.push_back(x);
  endtask

  // Monitor: every delivered response must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 attr=%0h expected no response", rsp_attr);
      end else begin
        e = exp_q.pop_front();
        if (rsp_fault !== e.fault || rsp_attr !== e.attr || (e.chk_data && rsp_data !== e.data))
        begin
          errors++;
          $display("FAIL rsp_match: got data=%0h fault=%0b attr=%0h expected data=%0h fault=%0b attr=%0h",
                   rsp_data, rsp_fault, rsp_attr, e.data, e.fault, e.attr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_fault = 1'b0; req_subunit = '0;
    req_attr = '0; unit_data_valid = '0; unit_data = '0; ifence = 1'b0;
    #3;
    check("reset_req_ready", 64'(req_ready), 64'd1);
    check("reset_inflight", 64'(inflight_count), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_ifence_start", 64'(ifence_start), 64'd0);
    check("reset_sub_new", 64'(sub_new_request), 64'd0);
    check("reset_perr", 64'(protocol_error), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Fill to DEPTH on sub-unit 1, then pop while a request is held off.
    for (int i = 0; i < 4; i++) begin
      cyc(); req_valid = 1'b1; req_subunit = 2'd1; req_attr = ATTR_W'(i);
      settle(); check("fill_sub_new", 64'(sub_new_request), 64'b010);
    end
    cyc(); req_attr = 34'h9; unit_data_valid = 3'b010; unit_data[63:32] = 32'hDEADBEEF;
    expect_rsp(32'hDEADBEEF, 1'b1, 1'b0, 34'h0);
    settle();
    check("full_inflight", 64'(inflight_count), 64'd4);
    check("full_req_ready", 64'(req_ready), 64'd0);
    check("full_no_push", 64'(sub_new_request), 64'd0);
    cyc(); req_valid = 1'b0; unit_data_valid = '0;
    settle();
    check("after_pop_ready", 64'(req_ready), 64'd1);
    check("after_pop_inflight", 64'(inflight_count), 64'd3);
    for (int i = 1; i < 4; i++) begin
      cyc(); unit_data_valid = 3'b010; unit_data[63:32] = 32'h1000 + 32'(i);
      expect_rsp(32'h1000 + 32'(i), 1'b1, 1'b0, ATTR_W'(i));
      settle();
    end
    cyc(); unit_data_valid = '0; settle();
    check("drain_inflight", 64'(inflight_count), 64'd0);

    // Fault entry completes the cycle after push without a memory request.
    cyc(); req_valid = 1'b1; req_fault = 1'b1; req_subunit = 2'd2; req_attr = 34'h5;
    settle();
    check("fault_sub_new", 64'(sub_new_request), 64'd0);
    check("fault_no_bypass", 64'(rsp_valid), 64'd0);
    cyc(); req_valid = 1'b0; req_fault = 1'b0;
    expect_rsp(32'h0, 1'b0, 1'b1, 34'h5);
    settle();
    check("fault_inflight", 64'(inflight_count), 64'd1);
    cyc(); settle();
    check("fault_drained", 64'(inflight_count), 64'd0);

    // Flush with two outstanding plus a same-cycle accept: three discards.
    cyc(); req_valid = 1'b1; req_subunit = 2'd0; req_attr = 34'h10; settle();
    cyc(); req_attr = 34'h11; settle();
    cyc(); req_attr = 34'h12; flush = 1'b1; settle();
    cyc(); req_valid = 1'b0; flush = 1'b0; settle();
    check("flush_inflight", 64'(inflight_count), 64'd3);
    for (int i = 0; i < 3; i++) begin
      cyc(); unit_data_valid = 3'b001; unit_data[31:0] = 32'hBAD0 + 32'(i);
      settle(); check("flush_discard", 64'(rsp_valid), 64'd0);
    end
    cyc(); unit_data_valid = '0; req_valid = 1'b1; req_attr = 34'h13; settle();
    cyc(); req_valid = 1'b0; unit_data_valid = 3'b001; unit_data[31:0] = 32'hCAFE0013;
    expect_rsp(32'hCAFE0013, 1'b1, 1'b0, 34'h13);
    settle();
    cyc(); unit_data_valid = '0; settle();
    check("flush_drained", 64'(inflight_count), 64'd0);

    // Flush coinciding with a head completion, one other outstanding.
    cyc(); req_valid = 1'b1; req_subunit = 2'd2; req_attr = 34'h20; settle();
    cyc(); req_attr = 34'h21; settle();
    cyc(); req_valid = 1'b0; unit_data_valid = 3'b100; unit_data[95:64] = 32'h2020;
    flush = 1'b1;
    settle(); check("flush_pop_same_cycle", 64'(rsp_valid), 64'd0);
    cyc(); flush = 1'b0; settle();
    check("flush_pop_next", 64'(rsp_valid), 64'd0);
    cyc(); unit_data_valid = '0; settle();
    check("flush_pop_inflight", 64'(inflight_count), 64'd0);

    // Fence drain with two outstanding.
    cyc(); req_valid = 1'b1; req_subunit = 2'd1; req_attr = 34'h30; settle();
    cyc(); req_attr = 34'h31; settle();
    cyc(); req_valid = 1'b0; ifence = 1'b1; settle();
    check("fence_ready_idle", 64'(req_ready), 64'd1);
    check("fence_start_early", 64'(ifence_start), 64'd0);
    cyc(); ifence = 1'b0; settle();
    check("fence_ready_pending", 64'(req_ready), 64'd0);
    check("fence_start_busy", 64'(ifence_start), 64'd0);
    cyc(); unit_data_valid = 3'b010; unit_data[63:32] = 32'h3030;
    expect_rsp(32'h3030, 1'b1, 1'b0, 34'h30);
    settle();
    cyc(); unit_data[63:32] = 32'h3131;
    expect_rsp(32'h3131, 1'b1, 1'b0, 34'h31);
    settle();
    check("fence_start_one_left", 64'(ifence_start), 64'd0);
    cyc(); unit_data_valid = '0; settle();
    check("fence_drained", 64'(inflight_count), 64'd0);
    check("fence_start_pulse", 64'(ifence_start), 64'd1);
    check("fence_ready_at_start", 64'(req_ready), 64'd0);
    cyc(); settle();
    check("fence_start_once", 64'(ifence_start), 64'd0);
    check("fence_ready_after", 64'(req_ready), 64'd1);
    cyc(); ifence = 1'b1; settle();
    check("fence_empty_same", 64'(ifence_start), 64'd0);
    cyc(); ifence = 1'b0; settle();
    check("fence_empty_next", 64'(ifence_start), 64'd1);
    cyc(); settle();
    check("fence_empty_once", 64'(ifence_start), 64'd0);

    // Stray valid on an empty FIFO sets a sticky error.
    cyc(); unit_data_valid = 3'b010; settle();
    check("perr_not_yet", 64'(protocol_error), 64'd0);
    cyc(); unit_data_valid = '0; settle();
    check("perr_empty_set", 64'(protocol_error), 64'd1);
    repeat (3) cyc();
    settle(); check("perr_sticky", 64'(protocol_error), 64'd1);
    cyc(); rst = 1'b1; #1;
    check("perr_rst_clear", 64'(protocol_error), 64'd0);
    cyc(); rst = 1'b0;

    // Wrong sub-unit returns while the head waits on sub-unit 0.
    cyc(); req_valid = 1'b1; req_subunit = 2'd0; req_attr = 34'h40; settle();
    cyc(); req_valid = 1'b0; unit_data_valid = 3'b100; settle();
    check("perr_wrong_no_rsp", 64'(rsp_valid), 64'd0);
    cyc(); unit_data_valid = '0; settle();
    check("perr_wrong_set", 64'(protocol_error), 64'd1);
    cyc(); unit_data_valid = 3'b001; unit_data[31:0] = 32'h4040;
    expect_rsp(32'h4040, 1'b1, 1'b0, 34'h40);
    settle();
    cyc(); unit_data_valid = '0; settle();
    check("perr_drained", 64'(inflight_count), 64'd0);

    // Asynchronous reset mid-operation.
    cyc(); req_valid = 1'b1; req_subunit = 2'd1; req_attr = 34'h50; settle();
    cyc(); req_valid = 1'b0; settle();
    check("arst_before", 64'(inflight_count), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_inflight", 64'(inflight_count), 64'd0);
    check("arst_ready", 64'(req_ready), 64'd1);
    check("arst_perr", 64'(protocol_error), 64'd0);
    check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    cyc(); rst = 1'b0;
    cyc(); settle();

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_inflight_tracker.md
# fetch_inflight_tracker

Parametrised in-order tracker for outstanding instruction-fetch requests, sitting between the fetch PC/TLB logic and the instruction memory sub-units (local memory, icache, bus). It generalises fetch in-flight bookkeeping to DEPTH outstanding requests and NUM_SUB_UNITS sources. It stores per-request attributes, steers each completion to the correct sub-unit and discards responses belonging to flushed requests. It adds an instruction-fence drain handshake and sticky detection of completions that do not match the oldest outstanding request.

## Interface
- DEPTH, default 4: maximum outstanding requests; any integer ≥ 1.
- NUM_SUB_UNITS, default 3: number of memory sub-units; ≥ 1.
- ATTR_W, default 34: width of the opaque per-request attribute word (prediction flags, early-flush PC).
- SUB_W (derived): max(1, $clog2(NUM_SUB_UNITS)). CNT_W (derived): $clog2(DEPTH+1).
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  discard every request outstanding at the end of this cycle.
- req_valid  in  1  launch request (TLB done, sub-units ready).
- req_ready  out  1  ~full & ~ifence_pending.
- req_fault  in  1  request is an MMU/access fault; no memory access is issued.
- req_subunit  in  SUB_W  target sub-unit index.
- req_attr  in  ATTR_W  attributes stored with the request.
- sub_new_request  out  NUM_SUB_UNITS  one-hot; bit req_subunit = req_valid & req_ready & ~req_fault.
- unit_data_valid  in  NUM_SUB_UNITS  per-sub-unit data return.
- unit_data  in  32*NUM_SUB_UNITS  flattened; sub-unit i occupies [32i+31:32i].
- rsp_valid  out  1  head request completed and was not flushed.
- rsp_data  out  32  unit_data slice of the head's sub-unit.
- rsp_fault  out  1  head's stored fault flag.
- rsp_attr  out  ATTR_W  head's stored attributes.
- inflight_count  out  CNT_W  registered occupancy.
- ifence  in  1  single-cycle fence request.
- ifence_start  out  1  pulse: pipeline drained, fence may be applied to the icache.
- protocol_error  out  1  sticky; cleared only by rst.

## Operation
- Circular FIFO of DEPTH entries {fault, subunit, attr}; write/read pointers wrap modulo DEPTH; occupancy counter is CNT_W bits.
- accept = req_valid & req_ready; push on accept. There is no push-when-full bypass, even if a pop occurs in the same cycle.
- head_done = ~empty & (head.fault | unit_data_valid[head.subunit]); pop on head_done.
- inflight_next = inflight_count + accept − head_done.
- discard_count (CNT_W): on flush it loads inflight_next. Otherwise it decrements on pop while nonzero.
- A request accepted in the flush cycle is therefore discarded, and a completion popped in the flush cycle is not counted.
- A flush arriving while discard_count ≠ 0 reloads the counter.
- rsp_valid = head_done & (discard_count == 0). Discarded completions still pop, with rsp_valid = 0.
- rsp_data, rsp_fault and rsp_attr are combinational from the head entry and the mux; their values are don't-care while rsp_valid = 0.
- protocol_error is set when any unit_data_valid bit is high and the FIFO is empty, or when a set bit ≠ head.subunit. A fault entry at the head does not excuse a stray valid.
- Fence FSM, IDLE → PENDING on ifence:
  - In PENDING, req_ready = 0.
  - When inflight_count == 0, assert ifence_start for one cycle and return to IDLE.
  - flush does not cancel PENDING.
  - ifence while PENDING is absorbed.

## Timing
- Reset values: all counters and pointers 0; FSM IDLE; protocol_error 0. As a result rsp_valid = 0, ifence_start = 0, sub_new_request = 0, inflight_count = 0 and req_ready = 1.
- sub_new_request is combinational in the accept cycle.
- Earliest completion is the cycle after push, including fault entries; there is no same-cycle bypass.
- Response latency is 0 cycles from the matching unit_data_valid (combinational rsp_valid).
- Throughput is 1 push and 1 pop per cycle; full occurs at DEPTH entries.
- ifence_start fires at the earliest in the cycle after ifence, provided inflight_count == 0.
- An asynchronous rst mid-operation clears everything immediately, and outputs take their reset values while rst is high.

## Test plan
- DEPTH=4: four non-fault pushes to sub-unit 1, none returned → inflight_count=4, req_ready=0. Then one unit_data_valid[1] with data 0xDEADBEEF → rsp_valid=1, rsp_data=0xDEADBEEF, and req_ready=1 the next cycle.
- Fault push with attr 0x5 → next cycle rsp_valid=1, rsp_fault=1, rsp_attr=0x5, and sub_new_request stays 0.
- Two outstanding, then flush in the same cycle as a third accept → discard_count=3. Three returns give rsp_valid=0; the fourth request's return gives rsp_valid=1.
- Flush in the same cycle as a head completion with one other request outstanding → that completion gives rsp_valid=0, discard_count=1, and the following return gives rsp_valid=0.
- ifence with 2 outstanding → req_ready=0. ifence_start pulses exactly once, in the cycle where inflight_count reads 0.
- Empty FIFO with unit_data_valid=3'b010, or a head on sub-unit 0 while sub-unit 2 returns → protocol_error=1 and it remains 1 until rst.
